// File: rtl/gpr_wb_arbiter_if.sv
// rtl/gpr_wb_arbiter_if.sv - writeback request bundle between result sources and the GPR write arbiter
//
// Purpose: carries the per-requester writeback handshake in flat vectors.
//   Requester k owns req_id[k*GPRS_WIDTH +: GPRS_WIDTH] and
//   req_data[k*DATA_WIDTH +: DATA_WIDTH].
// Signals:
//   req_valid [REQ_NUM]            requester has a result to write back
//   req_id    [REQ_NUM*GPRS_WIDTH] destination register indices
//   req_data  [REQ_NUM*DATA_WIDTH] write data
//   req_ready [REQ_NUM]            one-hot (or zero) grant from the arbiter
// Modports: master = writeback sources, slave = arbiter.
interface gpr_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5,
  parameter int REQ_NUM    = 3
);
  logic [REQ_NUM-1:0]            req_valid;
  logic [REQ_NUM*GPRS_WIDTH-1:0] req_id;
  logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
  logic [REQ_NUM-1:0]            req_ready;

  modport master (output req_valid, output req_id, output req_data, input req_ready);
  modport slave  (input req_valid, input req_id, input req_data, output req_ready);
endinterface

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - round-robin GPR writeback arbiter with registered write stage and busy scoreboard
//
// Purpose: shares the single GPR write port among REQ_NUM writeback sources
//   (requester 0 = ALU), registers the winning write, and tracks pending
//   destinations for RAW hazard stalls in decode.
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst_n        synchronous reset, ACTIVE-HIGH (1 = reset)
//   wb             writeback request bundle (slave side)
//   i_sb_set_en    issue reserves a destination
//   i_sb_set_id    destination being reserved
//   i_flush        pipeline flush: blocks grants, clears scoreboard
//   o_sb_busy      per-register pending flags, bit 0 always 0
//   o_gpr_wr_en    registered GPR write enable
//   o_gpr_wr_id    registered GPR write index
//   o_gpr_wr_data  registered GPR write data
//   o_grant_idx    requester that produced the current write
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5,
  parameter int REQ_NUM    = 3,
  localparam int PTR_W     = $clog2(REQ_NUM),
  localparam int NREG      = 1 << GPRS_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  gpr_wb_arbiter_if.slave       wb,
  input  logic                  i_sb_set_en,
  input  logic [GPRS_WIDTH-1:0] i_sb_set_id,
  input  logic                  i_flush,
  output logic [NREG-1:0]       o_sb_busy,
  output logic                  o_gpr_wr_en,
  output logic [GPRS_WIDTH-1:0] o_gpr_wr_id,
  output logic [DATA_WIDTH-1:0] o_gpr_wr_data,
  output logic [PTR_W-1:0]      o_grant_idx
);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [GPRS_WIDTH-1:0] wr_id_q, wr_id_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [PTR_W-1:0]      gidx_q, gidx_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [GPRS_WIDTH-1:0] sel_id;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin scan starting at ptr; reset and flush suppress every grant.
  always_comb begin
    int cand;
    grant_vld    = 1'b0;
    grant_idx    = '0;
    cand         = 0;
    wb.req_ready = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= REQ_NUM) cand = cand - REQ_NUM;
      if (!grant_vld && wb.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
    if (i_rst_n || i_flush) grant_vld = 1'b0;
    if (grant_vld) wb.req_ready[grant_idx] = 1'b1;
  end

  assign sel_id   = wb.req_id[int'(grant_idx)*GPRS_WIDTH +: GPRS_WIDTH];
  assign sel_data = wb.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d     = ptr_q;
    wr_id_d   = wr_id_q;
    wr_data_d = wr_data_q;
    gidx_d    = gidx_q;
    // x0 writes are accepted but never reach the register file.
    wr_en_d   = grant_vld && (sel_id != '0);
    if (grant_vld) begin
      ptr_d     = (grant_idx == PTR_W'(REQ_NUM-1)) ? '0 : grant_idx + 1'b1;
      wr_id_d   = sel_id;
      wr_data_d = sel_data;
      gidx_d    = grant_idx;
    end
  end

  // Clear on the GPR write, then set so a newer producer wins; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_id_q] = 1'b0;
    if (i_sb_set_en) busy_d[i_sb_set_id] = 1'b1;
    busy_d[0] = 1'b0;
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_id_q   <= '0;
      wr_data_q <= '0;
      gidx_q    <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_id_q   <= wr_id_d;
      wr_data_q <= wr_data_d;
      gidx_q    <= gidx_d;
      busy_q    <= busy_d;
    end
  end

  assign o_sb_busy     = busy_q;
  assign o_gpr_wr_en   = wr_en_q;
  assign o_gpr_wr_id   = wr_id_q;
  assign o_gpr_wr_data = wr_data_q;
  assign o_grant_idx   = gidx_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - scoreboard bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  localparam int DW = 32;
  localparam int GW = 5;
  localparam int RN = 3;

  typedef struct packed {
    logic [GW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    idx;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sb_set_en;
  logic [GW-1:0] sb_set_id;
  logic          flush;
  logic [31:0]   sb_busy;
  logic          gpr_wr_en;
  logic [GW-1:0] gpr_wr_id;
  logic [DW-1:0] gpr_wr_data;
  logic [1:0]    grant_idx;

  logic [GW-1:0] ids [RN];
  logic [DW-1:0] dats[RN];

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  gpr_wb_arbiter_if #(.DATA_WIDTH(DW), .GPRS_WIDTH(GW), .REQ_NUM(RN)) bus ();

  gpr_wb_arbiter #(.DATA_WIDTH(DW), .GPRS_WIDTH(GW), .REQ_NUM(RN)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .wb            (bus),
    .i_sb_set_en   (sb_set_en),
    .i_sb_set_id   (sb_set_id),
    .i_flush       (flush),
    .o_sb_busy     (sb_busy),
    .o_gpr_wr_en   (gpr_wr_en),
    .o_gpr_wr_id   (gpr_wr_id),
    .o_gpr_wr_data (gpr_wr_data),
    .o_grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One request cycle: drive valid, check the grant, queue the expected write,
  // then advance to just after the next rising edge.
  task automatic req_cycle(input logic [RN-1:0] v, input logic [RN-1:0] exp_rdy, input string nm);
    bus.req_valid = v;
    bus.req_id    = {ids[2], ids[1], ids[0]};
    bus.req_data  = {dats[2], dats[1], dats[0]};
    #2;
    chk(nm, 64'(bus.req_ready), 64'(exp_rdy));
    for (int k = 0; k < RN; k++)
      if (exp_rdy[k] && ids[k] != '0) exp_q.push_back('{id: ids[k], data: dats[k], idx: 2'(k)});
    @(posedge clk);
    #1;
  endtask

  task automatic std_ids();
    ids[0] = 5'd5; dats[0] = 32'h1111_0005;
    ids[1] = 5'd6; dats[1] = 32'h2222_0006;
    ids[2] = 5'd7; dats[2] = 32'h3333_0007;
  endtask

  // Monitor: every GPR write outside reset must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && gpr_wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got id=%0d data=%0h idx=%0d expected none",
                 gpr_wr_id, gpr_wr_data, grant_idx);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if ({gpr_wr_id, gpr_wr_data, grant_idx} !== w) begin
          bad++;
          $display("FAIL write: got id=%0d data=%0h idx=%0d expected id=%0d data=%0h idx=%0d",
                   gpr_wr_id, gpr_wr_data, grant_idx, w.id, w.data, w.idx);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sb_set_en = 1'b0; sb_set_id = '0; flush = 1'b0;
    std_ids();
    bus.req_valid = '1;
    bus.req_id    = {ids[2], ids[1], ids[0]};
    bus.req_data  = {dats[2], dats[1], dats[0]};
    @(posedge clk);
    #1;

    // Reset: two cycles with everyone valid.
    req_cycle(3'b111, 3'b000, "rst_ready_1");
    chk("rst_wr_en", 64'(gpr_wr_en), 64'd0);
    chk("rst_busy", 64'(sb_busy), 64'd0);
    req_cycle(3'b111, 3'b000, "rst_ready_2");
    rst = 1'b0;

    // Round robin with all valid.
    req_cycle(3'b111, 3'b001, "rr_0");
    req_cycle(3'b111, 3'b010, "rr_1");
    req_cycle(3'b111, 3'b100, "rr_2");
    req_cycle(3'b111, 3'b001, "rr_3");
    req_cycle(3'b111, 3'b010, "rr_4");
    req_cycle(3'b111, 3'b100, "rr_5");

    // x0 write: accepted, no GPR write, pointer moves to 2.
    ids[1] = 5'd0; dats[1] = 32'hDEAD_BEEF;
    req_cycle(3'b010, 3'b010, "x0_ready");
    chk("x0_no_wr", 64'(gpr_wr_en), 64'd0);
    std_ids();
    req_cycle(3'b111, 3'b100, "x0_ptr2");

    // Scoreboard set / clear / set-wins / id0 ignored.
    sb_set_en = 1'b1; sb_set_id = 5'd10;
    req_cycle(3'b000, 3'b000, "sb_idle");
    sb_set_en = 1'b0;
    chk("sb_set", 64'(sb_busy), 64'(32'h0000_0400));
    ids[2] = 5'd10; dats[2] = 32'hA5A5_0010;
    req_cycle(3'b100, 3'b100, "sb_wr1");
    chk("sb_hold", 64'(sb_busy), 64'(32'h0000_0400));
    sb_set_en = 1'b1; sb_set_id = 5'd10;
    req_cycle(3'b000, 3'b000, "sb_pulse1");
    sb_set_en = 1'b0;
    chk("sb_set_wins", 64'(sb_busy), 64'(32'h0000_0400));
    dats[2] = 32'h5A5A_0010;
    req_cycle(3'b100, 3'b100, "sb_wr2");
    chk("sb_pre_clr", 64'(sb_busy), 64'(32'h0000_0400));
    sb_set_en = 1'b1; sb_set_id = 5'd0;
    req_cycle(3'b000, 3'b000, "sb_pulse2");
    sb_set_en = 1'b0;
    chk("sb_cleared", 64'(sb_busy), 64'd0);

    // Flush.
    sb_set_en = 1'b1; sb_set_id = 5'd3;
    req_cycle(3'b000, 3'b000, "fl_idle");
    sb_set_id = 5'd4;
    ids[0] = 5'd12; dats[0] = 32'hC0C0_000C;
    req_cycle(3'b001, 3'b001, "fl_pre");
    chk("fl_busy_before", 64'(sb_busy), 64'(32'h0000_0018));
    sb_set_id = 5'd9; flush = 1'b1;
    ids[1] = 5'd14; dats[1] = 32'hE0E0_000E;
    req_cycle(3'b011, 3'b000, "fl_ready");
    sb_set_en = 1'b0; flush = 1'b0;
    chk("fl_busy_after", 64'(sb_busy), 64'd0);
    chk("fl_no_wr", 64'(gpr_wr_en), 64'd0);
    req_cycle(3'b011, 3'b010, "fl_ptr_held");

    // Mid-stream reset.
    sb_set_en = 1'b1; sb_set_id = 5'd20;
    bus.req_valid = 3'b010;
    #2;
    chk("mr_ready", 64'(bus.req_ready), 64'(3'b010));
    @(posedge clk);
    #1;
    sb_set_en = 1'b0; rst = 1'b1;
    chk("mr_busy_set", 64'(sb_busy), 64'(32'h0010_0000));
    std_ids();
    req_cycle(3'b111, 3'b000, "mr_ready_rst");
    rst = 1'b0;
    chk("mr_wr_en", 64'(gpr_wr_en), 64'd0);
    chk("mr_busy", 64'(sb_busy), 64'd0);
    req_cycle(3'b111, 3'b001, "mr_ptr0");
    req_cycle(3'b000, 3'b000, "mr_idle");
    req_cycle(3'b000, 3'b000, "end_idle");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Shares the single write port of the general-purpose register file between `REQ_NUM` writeback requesters (ALU, LSU load return, CSR/mul-div), using round-robin arbitration and a registered write stage. Maintains a 32-bit busy scoreboard: issue marks a destination register pending, and the register file write clears it. Sits between the execute/memory writeback sources and the GPR write port. Also feeds `o_sb_busy` to decode for RAW hazard stalls.

## Interface
- `DATA_WIDTH`, 32: register data width.
- `GPRS_WIDTH`, 5: register index width; the register count is 2^GPRS_WIDTH = 32.
- `REQ_NUM`, 3: number of writeback requesters (≥2); requester 0 is the ALU.
- `i_clk` in 1: single clock. All state updates on rising edge.
- `i_rst_n` in 1: reset, synchronous and active-high despite the `_n` suffix. Sampled on `i_clk`; 1 = reset.
- `i_req_valid` in REQ_NUM: per-requester writeback valid.
- `i_req_id` in REQ_NUM*GPRS_WIDTH: flat destination indices; requester k owns bits [k*GPRS_WIDTH +: GPRS_WIDTH].
- `i_req_data` in REQ_NUM*DATA_WIDTH: flat write data; same packing as `i_req_id`.
- `o_req_ready` out REQ_NUM: one-hot (or zero) grant. Transfer happens when valid & ready.
- `i_sb_set_en` in 1: issue stage reserves a destination.
- `i_sb_set_id` in GPRS_WIDTH: destination being reserved.
- `i_flush` in 1: pipeline flush.
- `o_sb_busy` out 32: per-register pending flag; bit 0 is constantly 0.
- `o_gpr_wr_en` out 1: GPR write enable, registered.
- `o_gpr_wr_id` out GPRS_WIDTH: GPR write index, registered.
- `o_gpr_wr_data` out DATA_WIDTH: GPR write data, registered.
- `o_grant_idx` out $clog2(REQ_NUM): index of the requester written this cycle; valid while `o_gpr_wr_en`=1.

## Operation
- **Round-robin pointer `ptr`** (0..REQ_NUM-1).
  - Grant goes to the first k with `i_req_valid[k]`=1, scanning ptr, ptr+1, … modulo REQ_NUM.
  - `o_req_ready[k]` = 1 only for that k. Ready is combinational from valid and `ptr`.
  - On acceptance, `ptr` ← (k+1) mod REQ_NUM. With no acceptance, `ptr` holds.
- **Write stage.** Every cycle, the write stage loads the accepted request: `wr_en` ← accepted && id≠0, `wr_id` ← id, `wr_data` ← data, `grant_idx` ← k.
  - With no acceptance, `wr_en` ← 0; id/data/grant_idx hold.
  - A write to x0 is accepted (ready asserted) but never drives `o_gpr_wr_en`.
- **The GPR port never stalls**, so throughput is one writeback per cycle. Losing requesters see ready=0 and must hold valid/id/data stable.
- **Scoreboard, per bit r≠0.**
  - Set when `i_sb_set_en`=1 and `i_sb_set_id`=r.
  - Cleared when `o_gpr_wr_en`=1 and `o_gpr_wr_id`=r, i.e. in the same cycle the GPR captures the data.
  - Set and clear on the same r in the same cycle: set wins (a newer producer).
  - Set with id 0 is ignored.
- **Flush (`i_flush`=1).**
  - All `o_req_ready`=0; no acceptance and `ptr` holds.
  - All busy bits ← 0, and this overrides a same-cycle set.
  - A write already registered in the write stage still completes that cycle.

## Timing
- **Reset** (`i_rst_n`=1 at an edge):
  - `ptr`=0, `o_gpr_wr_en`=0, `o_gpr_wr_id`=0, `o_gpr_wr_data`=0, `o_grant_idx`=0, `o_sb_busy`=0.
  - `o_req_ready` is all 0 during any cycle `i_rst_n`=1.
  - Reset mid-stream drops the registered write: the `o_gpr_wr_en` pulse after that edge is 0.
  - Reset overrides flush and set.
- **Latency:** acceptance at edge N → `o_gpr_wr_en`=1 during cycle N+1 → GPR updated at edge N+2. The busy bit reads 0 from cycle N+2.
- **Ready** is combinational from `i_req_valid`, `ptr`, `i_flush`, `i_rst_n`. There is no combinational path from `i_req_data` to any output.
- **Busy** updates are registered: a set at edge N shows `o_sb_busy[r]`=1 from cycle N+1.

## Test plan
- **Reset:** hold `i_rst_n`=1 for 2 cycles with all requesters valid → all ready=0, `o_gpr_wr_en`=0, `o_sb_busy`=0. Release → requester 0 granted first.
- **Round robin:** all 3 requesters valid continuously, ids 5/6/7 → grants 0,1,2,0,1,2. Writes x5,x6,x7,x5…, one per cycle, each 1 cycle after grant.
- **x0 drop:** requester 1 alone, id 0, data 0xDEADBEEF → ready=1 and ptr advances to 2. `o_gpr_wr_en` stays 0.
- **Scoreboard:** set x10 at edge N → busy[10]=1. Requester 2 writes x10 accepted at N+3 → `o_gpr_wr_en`=1 at N+4, busy[10]=0 from N+5. A set x10 in the clear cycle keeps busy[10]=1.
- **Flush:** busy x3,x4 set, requester 0 valid; assert `i_flush` → ready=0 and busy=0 next cycle. The previously registered write still pulses `o_gpr_wr_en`.
- **Mid-stream reset:** request accepted at edge N, `i_rst_n`=1 at edge N+1 → no `o_gpr_wr_en` pulse. Pointer=0 and busy=0 after reset.
